// File: rtl/netdly_pkg.sv
// Shared types and defaults for the per-pin delay eye trainer.
package netdly_pkg;

    localparam int NBITS_DEF  = 16;
    // Matches the ECP5 DELAYF tap range.
    localparam int MAXTAP_DEF = 127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_CENTER,
        S_DONE
    } state_e;

endpackage

// File: rtl/netdly_win_track.sv
// Tracks the current error-free run and the longest run seen so far.
module netdly_win_track
    import netdly_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_eval,
    input  logic             i_pass,
    input  logic [NBITS-1:0] i_tap,
    output logic [NBITS-1:0] o_best_start,
    output logic [NBITS-1:0] o_best_len
);

    logic [NBITS-1:0] run_start_q, run_start_d;
    logic [NBITS-1:0] run_len_q, run_len_d;
    logic [NBITS-1:0] best_start_q, best_len_q;

    always_comb begin
        run_len_d   = i_pass ? run_len_q + 1'b1 : '0;
        run_start_d = run_start_q;
        if (i_pass && run_len_q == '0) run_start_d = i_tap;
    end

    // Strictly greater keeps the lowest-tap window on ties.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (i_clear) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (i_eval) begin
            run_start_q <= run_start_d;
            run_len_q   <= run_len_d;
            if (run_len_d > best_len_q) begin
                best_start_q <= run_start_d;
                best_len_q   <= run_len_d;
            end
        end
    end

    assign o_best_start = best_start_q;
    assign o_best_len   = best_len_q;

endmodule

// File: rtl/netdly_eye_trainer.sv
// Sweeps delay taps, scores each by sample errors, centres the widest clean run.
// Define NETDLY_PASSMAP_EN to add the o_pass_map per-tap result output.
module netdly_eye_trainer
    import netdly_pkg::*;
#(
    parameter int NBITS   = NBITS_DEF,
    parameter int MAXTAP  = MAXTAP_DEF,
    parameter int SETTLE  = 16,
    parameter int MEASLG  = 10,
    parameter int TIMEOUT = 4096,
    parameter int MINWIN  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_current_delay,
    input  logic             i_sample_valid,
    input  logic             i_sample_err,
    output logic [NBITS-1:0] o_commanded_delay,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fail,
    output logic [NBITS-1:0] o_win_start,
    output logic [NBITS-1:0] o_win_len
`ifdef NETDLY_PASSMAP_EN
    ,
    output logic [MAXTAP:0]  o_pass_map
`endif
);

    localparam int CW = $clog2(TIMEOUT + SETTLE + 1) + 1;

    state_e           state_q, state_d;
    logic [NBITS-1:0] tap_q, tap_d, cmd_q, cmd_d, prev_q, prev_d;
    logic [NBITS-1:0] ws_q, ws_d, wl_q, wl_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [MEASLG:0]  smp_q, smp_d;
    logic             err_q, err_d, send_q, send_d;
    logic             fail_q, fail_d, ofail_q, ofail_d;
    logic [NBITS-1:0] best_start, best_len, centre;
    logic             start_ok, win_eval;

    assign start_ok = (state_q == S_IDLE) && i_start;
    assign win_eval = (state_q == S_EVAL) && !send_q;
    assign centre   = best_start + ((best_len - 1'b1) >> 1);

    netdly_win_track #(.NBITS(NBITS)) u_win (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clear     (start_ok),
        .i_eval      (win_eval),
        .i_pass      (!err_q),
        .i_tap       (tap_q),
        .o_best_start(best_start),
        .o_best_len  (best_len)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            cmd_q   <= '0;
            prev_q  <= '0;
            ws_q    <= '0;
            wl_q    <= '0;
            cnt_q   <= '0;
            smp_q   <= '0;
            err_q   <= 1'b0;
            send_q  <= 1'b0;
            fail_q  <= 1'b0;
            ofail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cmd_q   <= cmd_d;
            prev_q  <= prev_d;
            ws_q    <= ws_d;
            wl_q    <= wl_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            err_q   <= err_d;
            send_q  <= send_d;
            fail_q  <= fail_d;
            ofail_q <= ofail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        cmd_d   = cmd_q;
        prev_d  = prev_q;
        ws_d    = ws_q;
        wl_d    = wl_q;
        cnt_d   = cnt_q;
        smp_d   = smp_q;
        err_d   = err_q;
        send_d  = send_q;
        fail_d  = fail_q;
        ofail_d = ofail_q;
        unique case (state_q)
            S_IDLE: if (i_start) begin
                prev_d  = cmd_q;
                tap_d   = '0;
                cmd_d   = '0;
                cnt_d   = '0;
                send_d  = 1'b0;
                fail_d  = 1'b0;
                state_d = S_SEEK;
            end
            S_SEEK: begin
                if (i_current_delay == tap_q) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    send_d  = 1'b1;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    smp_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_MEASURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEASURE: if (i_sample_valid) begin
                smp_d = smp_q + 1'b1;
                err_d = err_q | i_sample_err;
                if (smp_d[MEASLG]) state_d = S_EVAL;
            end
            S_EVAL: begin
                cnt_d = '0;
                if (send_q || tap_q == NBITS'(MAXTAP)) begin
                    state_d = S_CENTER;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    cmd_d   = tap_q + 1'b1;
                    state_d = S_SEEK;
                end
            end
            S_CENTER: begin
                if (best_len < NBITS'(MINWIN)) begin
                    cmd_d   = prev_q;
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cmd_d = centre;
                    if (i_current_delay == centre) begin
                        state_d = S_DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Results become visible together with the done pulse.
        if (state_d == S_DONE && state_q != S_DONE) begin
            ofail_d = fail_d;
            ws_d    = best_start;
            wl_d    = best_len;
        end
    end

    always_comb begin
        o_busy            = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done            = (state_q == S_DONE);
        o_fail            = ofail_q;
        o_win_start       = ws_q;
        o_win_len         = wl_q;
        o_commanded_delay = cmd_q;
    end

`ifdef NETDLY_PASSMAP_EN
    logic [MAXTAP:0] pmap_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pmap_q <= '0;
        end else if (start_ok) begin
            pmap_q <= '0;
        end else if (win_eval && !err_q) begin
            for (int i = 0; i <= MAXTAP; i++) begin
                if (tap_q == NBITS'(i)) pmap_q[i] <= 1'b1;
            end
        end
    end

    assign o_pass_map = pmap_q;
`endif

endmodule

// File: tb/tb_netdly_eye_trainer.sv
// Directed bench for netdly_eye_trainer: ideal 8-cycle delay stage model,
// per-scenario clean-tap ranges, optional saturation of the delay stage.
module tb_netdly_eye_trainer;

    localparam int NB = 16;
    localparam int MT = 127;

    typedef struct {
        int g0lo;
        int g0hi;
        int g1lo;
        int g1hi;
        int sat;
        bit restart;
        bit efail;
        int estart;
        int elen;
        int ecmd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] cur, cmd, ws, wl;
    logic          vld_q, serr, busy, done, fail;
`ifdef NETDLY_PASSMAP_EN
    logic [MT:0]   pmap;
    logic [MT:0]   exp_map;
`endif

    int g0lo = 1, g0hi = 0, g1lo = 1, g1hi = 0, sat = 100000;
    int tests = 0, fails = 0, done_seen = 0;
    int pv, cv;
    bit good;
    logic [NB-1:0] pipe [8];
    vec_t vecs [8];

    always #5 clk = ~clk;

    netdly_eye_trainer #(
        .NBITS(NB), .MAXTAP(MT), .SETTLE(2), .MEASLG(2),
        .TIMEOUT(32), .MINWIN(4)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_start          (start),
        .i_current_delay  (cur),
        .i_sample_valid   (vld_q),
        .i_sample_err     (serr),
        .o_commanded_delay(cmd),
        .o_busy           (busy),
        .o_done           (done),
        .o_fail           (fail),
        .o_win_start      (ws),
        .o_win_len        (wl)
`ifdef NETDLY_PASSMAP_EN
        ,
        .o_pass_map       (pmap)
`endif
    );

    // Delay stage: follows the command 8 cycles late, clipped at sat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) pipe[i] <= '0;
            vld_q <= 1'b0;
        end else begin
            pipe[0] <= cmd;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
            vld_q <= ~vld_q;
        end
    end

    // Error line is forced high on non-valid cycles to check qualification.
    always_comb begin
        pv   = int'(pipe[7]);
        cur  = (pv > sat) ? NB'(sat) : pipe[7];
        cv   = int'(cur);
        good = (cv >= g0lo && cv <= g0hi) || (cv >= g1lo && cv <= g1hi);
        serr = ~vld_q | ~good;
    end

    always @(negedge clk) if (done) done_seen++;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int d0;
        bit got;
        g0lo = v.g0lo; g0hi = v.g0hi;
        g1lo = v.g1lo; g1hi = v.g1hi;
        sat  = v.sat;
        d0   = done_seen;
        pulse_start();
        chk({nm, "_busy"}, int'(busy), 1);
        if (v.restart) begin
            repeat (300) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, int'(got), 1);
        if (got) begin
            chk({nm, "_fail"}, int'(fail), int'(v.efail));
            chk({nm, "_start"}, int'(ws), v.estart);
            chk({nm, "_len"}, int'(wl), v.elen);
            chk({nm, "_cmd"}, int'(cmd), v.ecmd);
            chk({nm, "_busy_done"}, int'(busy), 0);
        end
        repeat (3) @(negedge clk);
        chk({nm, "_done_pulses"}, done_seen - d0, 1);
        chk({nm, "_cmd_hold"}, int'(cmd), v.ecmd);
    endtask

    initial begin
        vecs[0] = '{0, 19, 40, 69, 100000, 1'b1, 1'b0, 40, 30, 54};
        vecs[1] = '{10, 17, 50, 57, 100000, 1'b0, 1'b0, 10, 8, 13};
        vecs[2] = '{30, 36, 1, 0, 100000, 1'b0, 1'b0, 30, 7, 33};
        vecs[3] = '{1, 0, 1, 0, 100000, 1'b0, 1'b1, 0, 0, 33};
        vecs[4] = '{5, 7, 1, 0, 100000, 1'b0, 1'b1, 5, 3, 33};
        vecs[5] = '{0, 2, 100, 103, 100000, 1'b0, 1'b0, 100, 4, 101};
        vecs[6] = '{0, 6, 120, 127, 100000, 1'b0, 1'b0, 120, 8, 123};
        vecs[7] = '{0, 127, 1, 0, 60, 1'b0, 1'b0, 0, 61, 30};

        repeat (3) @(negedge clk);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_ws", int'(ws), 0);
        chk("rst_wl", int'(wl), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
`ifdef NETDLY_PASSMAP_EN
            if (i == 0) begin
                exp_map = '0;
                for (int t = 0; t <= 19; t++) exp_map[t] = 1'b1;
                for (int t = 40; t <= 69; t++) exp_map[t] = 1'b1;
                tests++;
                if (pmap !== exp_map) begin
                    fails++;
                    $display("FAIL passmap: got %h, expected %h", pmap, exp_map);
                end
            end
`endif
        end

        // Reset in the middle of measuring tap 25.
        g0lo = 0; g0hi = 19; g1lo = 40; g1hi = 69; sat = 100000;
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 5000 && !seen; c++) begin
                @(negedge clk);
                if (cmd == NB'(25)) seen = 1'b1;
            end
            chk("rst_mid_reach25", int'(seen), 1);
        end
        repeat (13) @(negedge clk);
        chk("rst_mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_cmd", int'(cmd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], "retrain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
